// File: rtl/cla_result_collector.sv
// cla_result_collector
// Downstream stage of a fixed-latency, unstallable pipelined CLA adder. A tag pipe runs alongside
// the adder recording which cycles carried real operands (plus the operand sign bits). When a
// valid tag reaches the last stage, the adder's Sum/Cout are captured together with a signed
// overflow flag and written into a small result FIFO with a valid/ready output.
// Issue flow control is credit based: an issue is only accepted when the FIFO entries plus the
// results still travelling through the adder leave a free slot, so a write is never refused.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   issue_valid      operands presented to the adder this cycle
//   issue_ready      collector can accept an issue this cycle (registered-state only)
//   issue_a_msb/b_msb  sign bits of the issued operands
//   sum, cout        adder outputs, valid LATENCY edges after issue
//   out_valid/ready  result FIFO handshake
//   out_sum/cout/ovf head entry, zero when out_valid is low
//   level            FIFO occupancy (excludes results still in the adder)
// Optional build macro COLLECTOR_STATS_EN adds stat_results / stat_ovf counters (32-bit, wrapping).
module cla_result_collector #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic                       issue_a_msb,
  input  logic                       issue_b_msb,
  input  logic [WIDTH-1:0]           sum,
  input  logic                       cout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_sum,
  output logic                       out_cout,
  output logic                       out_ovf,
  output logic [$clog2(DEPTH+1)-1:0] level
`ifdef COLLECTOR_STATS_EN
  ,
  output logic [31:0]                stat_results,
  output logic [31:0]                stat_ovf
`endif
);

  localparam int unsigned LevelW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned EntryW = WIDTH + 2;

  // ---------------------------------------------------------------------------------------------
  // Tag pipe: stage 0 loads on an accepted issue, stage LATENCY-1 lines up with the adder output.
  // ---------------------------------------------------------------------------------------------
  logic               issue_fire;
  logic [LATENCY-1:0] tag_valid_q, tag_valid_d;
  logic [LATENCY-1:0] tag_a_q, tag_a_d;
  logic [LATENCY-1:0] tag_b_q, tag_b_d;
  logic [LATENCY:0]   valid_shift, a_shift, b_shift;

  assign issue_fire = issue_valid & issue_ready;

  always_comb begin
    valid_shift = {tag_valid_q, issue_fire};
    a_shift     = {tag_a_q, issue_a_msb};
    b_shift     = {tag_b_q, issue_b_msb};
    tag_valid_d = valid_shift[LATENCY-1:0];
    tag_a_d     = a_shift[LATENCY-1:0];
    tag_b_d     = b_shift[LATENCY-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid_q <= '0;
      tag_a_q     <= '0;
      tag_b_q     <= '0;
    end else begin
      tag_valid_q <= tag_valid_d;
      tag_a_q     <= tag_a_d;
      tag_b_q     <= tag_b_d;
    end
  end

  // Results still inside the adder hold a FIFO credit until they are written.
  logic [31:0] inflight;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + 32'(tag_valid_q[i]);
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Capture and result FIFO
  // ---------------------------------------------------------------------------------------------
  logic              push, pop;
  logic              wr_ovf;
  logic [EntryW-1:0] wr_data;
  logic [EntryW-1:0] head;
  logic [EntryW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] count_q, count_d;

  // Same-sign operands producing a result of the other sign; Cin cannot change this outcome
  // except via the sum itself, so it is not needed.
  assign wr_ovf  = (tag_a_q[LATENCY-1] == tag_b_q[LATENCY-1]) &
                   (sum[WIDTH-1] != tag_a_q[LATENCY-1]);
  assign wr_data = {wr_ovf, cout, sum};
  assign push    = tag_valid_q[LATENCY-1];
  assign pop     = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    count_d = count_q + LevelW'(push) - LevelW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Outputs (all derived from registered state)
  // ---------------------------------------------------------------------------------------------
  assign head        = mem_q[rd_ptr_q];
  assign out_valid   = (count_q != '0);
  assign out_sum     = out_valid ? head[WIDTH-1:0] : '0;
  assign out_cout    = out_valid ? head[WIDTH]     : 1'b0;
  assign out_ovf     = out_valid ? head[WIDTH+1]   : 1'b0;
  assign level       = count_q;
  assign issue_ready = (32'(count_q) + inflight) < DEPTH;

`ifdef COLLECTOR_STATS_EN
  logic [31:0] stat_results_q, stat_ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_results_q <= '0;
      stat_ovf_q     <= '0;
    end else if (push) begin
      stat_results_q <= stat_results_q + 32'd1;
      stat_ovf_q     <= stat_ovf_q + 32'(wr_ovf);
    end
  end

  assign stat_results = stat_results_q;
  assign stat_ovf     = stat_ovf_q;
`endif

endmodule

// File: tb/tb_cla_result_collector.sv
// Bench for cla_result_collector (WIDTH=32, LATENCY=2, DEPTH=4) with a 2-stage adder model.
module tb_cla_result_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic [2:0]  level;
  logic [31:0] sum;
  logic        cout;
  logic [31:0] a_drv = '0;
  logic [31:0] b_drv = '0;
  logic        cin_drv = 1'b0;
  logic [32:0] s1_q, s2_q;
`ifdef COLLECTOR_STATS_EN
  logic [31:0] stat_results;
  logic [31:0] stat_ovf;
`endif

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Pipelined adder model, latency 2, sharing the collector reset.
  always @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= {1'b0, a_drv} + {1'b0, b_drv} + {32'd0, cin_drv};
      s2_q <= s1_q;
    end
  end
  assign sum  = s2_q[31:0];
  assign cout = s2_q[32];

  cla_result_collector #(
    .WIDTH  (32),
    .LATENCY(2),
    .DEPTH  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .issue_a_msb(a_drv[31]),
    .issue_b_msb(b_drv[31]),
    .sum        (sum),
    .cout       (cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_cout   (out_cout),
    .out_ovf    (out_ovf),
    .level      (level)
`ifdef COLLECTOR_STATS_EN
    ,
    .stat_results(stat_results),
    .stat_ovf    (stat_ovf)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    issue_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    n_checks++;
    if (issue_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_issue_ready: got %b want 1", issue_ready);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_checks++;
    if (level !== 3'd0) begin
      n_fail++; $display("FAIL reset_level: got %0d want 0", level);
    end
    n_checks++;
    if ({out_sum, out_cout, out_ovf} !== 34'd0) begin
      n_fail++; $display("FAIL reset_out_zero: got %h/%b/%b want 0", out_sum, out_cout, out_ovf);
    end
  endtask

  // One isolated issue per vector: out_valid must rise exactly 3 cycles after issue.
  task automatic test_single_results();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] es [3];
    logic        ec [3];
    logic        eo [3];
    va[0] = 32'h7FFF_FFFF; vb[0] = 32'h0000_0001; es[0] = 32'h8000_0000; ec[0] = 0; eo[0] = 1;
    va[1] = 32'hFFFF_FFFF; vb[1] = 32'h0000_0001; es[1] = 32'h0000_0000; ec[1] = 1; eo[1] = 0;
    va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000; es[2] = 32'h0000_0000; ec[2] = 1; eo[2] = 1;
    out_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      issue_valid = 1'b1;
      a_drv = va[v];
      b_drv = vb[v];
      tick();
      issue_valid = 1'b0;
      for (int c = 1; c <= 2; c++) begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++; $display("FAIL single%0d_early_valid cycle %0d: got %b want 0", v, c, out_valid);
        end
        tick();
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== es[v] || out_cout !== ec[v] || out_ovf !== eo[v]) begin
        n_fail++;
        $display("FAIL single%0d_result: got v=%b sum=%h cout=%b ovf=%b want v=1 sum=%h cout=%b ovf=%b",
                 v, out_valid, out_sum, out_cout, out_ovf, es[v], ec[v], eo[v]);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL single%0d_popped: got out_valid=%b want 0", v, out_valid);
      end
    end
  endtask

  // Consumer stalled, issue held: exactly four accepted, then results drain in order.
  task automatic test_fill();
    out_ready = 1'b0;
    b_drv = 32'd0;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (issue_ready !== (k < 4)) begin
        n_fail++; $display("FAIL fill_issue_ready cycle %0d: got %b want %b", k, issue_ready, k < 4);
      end
      issue_valid = 1'b1;
      a_drv = 32'(100 + k);
      tick();
    end
    issue_valid = 1'b0;
    n_checks++;
    if (level !== 3'd4 || out_valid !== 1'b1 || out_sum !== 32'd100) begin
      n_fail++; $display("FAIL fill_full: got level=%0d v=%b sum=%0d want 4/1/100", level, out_valid, out_sum);
    end
    tick();
    n_checks++;
    if (out_sum !== 32'd100 || level !== 3'd4) begin
      n_fail++; $display("FAIL fill_stall_stable: got sum=%0d level=%0d want 100/4", out_sum, level);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== 32'(100 + k)) begin
        n_fail++; $display("FAIL fill_drain%0d: got v=%b sum=%0d want 1/%0d", k, out_valid, out_sum, 100 + k);
      end
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      n_fail++; $display("FAIL fill_empty: got v=%b level=%0d want 0/0", out_valid, level);
    end
  endtask

  // Start from a full FIFO, then issue and pop every cycle.
  task automatic test_back_to_back();
    logic [31:0] q [$];
    logic [31:0] exp_v;
    int          k;
    int          both_cnt;
    bit          filled;
    out_ready = 1'b0;
    b_drv = 32'd5;
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1'b1;
      a_drv = 32'(200 + i);
      q.push_back(32'(205 + i));
      tick();
    end
    issue_valid = 1'b0;
    filled = 1'b0;
    for (int t = 0; t < 10 && !filled; t++) begin
      if (level == 3'd4) filled = 1'b1;
      else tick();
    end
    n_checks++;
    if (!filled) begin
      n_fail++; $display("FAIL b2b_fill_timeout: got level=%0d want 4", level);
    end
    out_ready = 1'b1;
    issue_valid = 1'b1;
    k = 0;
    both_cnt = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      a_drv = 32'(300 + k);
      if (cyc >= 2 && issue_ready && out_valid) both_cnt++;
      if (out_valid) begin
        exp_v = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
        n_checks++;
        if (out_sum !== exp_v) begin
          n_fail++; $display("FAIL b2b_order cycle %0d: got %0d want %0d", cyc, out_sum, exp_v);
        end
      end
      if (issue_ready) begin
        q.push_back(32'(305 + k));
        k++;
      end
      tick();
    end
    n_checks++;
    if (both_cnt != 18) begin
      n_fail++; $display("FAIL b2b_throughput: got %0d cycles want 18", both_cnt);
    end
    issue_valid = 1'b0;
    for (int t = 0; t < 20 && q.size() > 0; t++) begin
      if (out_valid) begin
        exp_v = q.pop_front();
        n_checks++;
        if (out_sum !== exp_v) begin
          n_fail++; $display("FAIL b2b_drain_order: got %0d want %0d", out_sum, exp_v);
        end
      end
      tick();
    end
    n_checks++;
    if (q.size() != 0 || out_valid !== 1'b0 || level !== 3'd0) begin
      n_fail++; $display("FAIL b2b_drained: got left=%0d v=%b level=%0d want 0/0/0", q.size(), out_valid, level);
    end
  endtask

  // Reset one cycle after two issues discards them; a later issue returns only its own result.
  task automatic test_reset_mid();
    out_ready = 1'b1;
    b_drv = 32'd0;
    issue_valid = 1'b1;
    a_drv = 32'h11;
    tick();
    a_drv = 32'h22;
    tick();
    issue_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (out_valid !== 1'b0 || level !== 3'd0) begin
        n_fail++; $display("FAIL rstmid_quiet cycle %0d: got v=%b level=%0d want 0/0", c, out_valid, level);
      end
      tick();
    end
    issue_valid = 1'b1;
    a_drv = 32'h33;
    b_drv = 32'h1;
    tick();
    issue_valid = 1'b0;
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'h34 || out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_result: got v=%b sum=%h ovf=%b want 1/34/0", out_valid, out_sum, out_ovf);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_extra cycle %0d: got v=%b want 0", c, out_valid);
      end
    end
  endtask

`ifdef COLLECTOR_STATS_EN
  task automatic test_stats();
    logic [31:0] va [5];
    logic [31:0] vb [5];
    va[0] = 32'h7FFF_FFFF; vb[0] = 32'h1;
    va[1] = 32'h8000_0000; vb[1] = 32'h8000_0000;
    va[2] = 32'h1;         vb[2] = 32'h1;
    va[3] = 32'h2;         vb[3] = 32'h2;
    va[4] = 32'h3;         vb[4] = 32'h3;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (stat_results !== 32'd0 || stat_ovf !== 32'd0) begin
      n_fail++; $display("FAIL stats_reset: got %0d/%0d want 0/0", stat_results, stat_ovf);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue_valid = 1'b1;
      a_drv = va[i];
      b_drv = vb[i];
      tick();
    end
    issue_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (stat_results !== 32'd5 || stat_ovf !== 32'd2) begin
      n_fail++; $display("FAIL stats_count: got %0d/%0d want 5/2", stat_results, stat_ovf);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_results();
    test_fill();
    test_back_to_back();
    test_reset_mid();
`ifdef COLLECTOR_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
